// File: rtl/column_collision_scorer_pkg.sv
// ============================================================================
// Module  : column_collision_scorer_pkg
// Brief   : Shared screen/pipe/bird geometry, game-state encodings and a
//           BCD magnitude helper for the column collision scorer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package column_collision_scorer_pkg;

  // Screen and playfield geometry (pixels)
  localparam int C_SCREEN_WIDTH  = 640;
  localparam int C_SCREEN_HEIGHT = 480;
  localparam int C_PADDING       = 10;

  // Pipe and gap geometry
  localparam int C_PIPE_W        = 20;
  localparam int C_GAP_H         = 60;

  // Bird geometry
  localparam int C_BIRD_X        = 100;
  localparam int C_BIRD_W        = 16;
  localparam int C_BIRD_H        = 16;

  // gameState encodings
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_DEAD = 2'b10;

  typedef logic [15:0] bcd4_t;

  // True when BCD value a is strictly greater than b; the first differing
  // digit, scanning from the most significant one, decides.
  function automatic logic bcd_gt(input bcd4_t a, input bcd4_t b);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
        gt      = (a[4*i +: 4] > b[4*i +: 4]);
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/column_collision_scorer_bcd_counter4.sv
// ============================================================================
// Module  : column_collision_scorer_bcd_counter4
// Brief   : 4-digit BCD up-counter with synchronous active-low clear,
//           ripple digit carry and saturation at 9999.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module column_collision_scorer_bcd_counter4
  import column_collision_scorer_pkg::*;
(
  input  logic        clk_i,
  input  logic        clr_ni,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  bcd4_t count_q;
  bcd4_t count_d;
  logic  carry;

  // Next count: ripple a carry from the least significant digit upward,
  // holding the value once every digit reads 9.
  always_comb begin
    count_d = count_q;
    carry   = 1'b1;
    if (inc_i && (count_q != 16'h9999)) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (count_q[4*i +: 4] == 4'd9) begin
            count_d[4*i +: 4] = 4'd0;
          end else begin
            count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  // Count register with synchronous clear
  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/column_collision_scorer.sv
// ============================================================================
// Module  : column_collision_scorer
// Brief   : Two-stage collision pipeline (columns, floor, ceiling), game
//           state machine and 4-digit BCD score. Optional high-score
//           register enabled by defining HISCORE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module column_collision_scorer
  import column_collision_scorer_pkg::*;
#(
  parameter int SCREEN_HEIGHT = C_SCREEN_HEIGHT,
  parameter int PADDING       = C_PADDING,
  parameter int PIPE_W        = C_PIPE_W,
  parameter int GAP_H         = C_GAP_H,
  parameter int BIRD_X        = C_BIRD_X,
  parameter int BIRD_W        = C_BIRD_W,
  parameter int BIRD_H        = C_BIRD_H
) (
  input  logic        gameClk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] birdY,
  input  logic [10:0] Ax,
  input  logic [10:0] Ay,
  input  logic [10:0] Bx,
  input  logic [10:0] By,
  input  logic        passColumn,
  output logic        finished,
  output logic        collided,
  output logic [15:0] score,
  output logic [1:0]  gameState
`ifdef HISCORE_EN
  ,
  output logic [15:0] hiScore
`endif
);

  // 12-bit compare constants: one guard bit keeps 11-bit sums from wrapping
  localparam logic [11:0] C_X_LO  = 12'(BIRD_X);
  localparam logic [11:0] C_X_HI  = 12'(BIRD_X + BIRD_W + 2*PIPE_W - 2);
  localparam logic [11:0] C_GAP   = 12'(GAP_H);
  localparam logic [11:0] C_BH    = 12'(BIRD_H);
  localparam logic [11:0] C_BH_M1 = 12'(BIRD_H - 1);
  localparam logic [11:0] C_PAD   = 12'(PADDING);
  localparam logic [11:0] C_Y_MAX = 12'(SCREEN_HEIGHT - PADDING);

  // Start edge detector
  logic start_prev_q;
  logic start_rise;

  // Stage 1: registered inputs
  logic [10:0] birdy_q, ax_q, ay_q, bx_q, by_q;
  logic        pass1_q;

  // Stage 2: registered hit and delayed pass
  logic hit_q, pass2_q;

  // State machine and outputs
  logic [1:0] state_q, state_d;
  logic       finished_q, collided_q, collided_d;
  logic       score_clr;
  logic       score_inc;
  logic       flush;
  bcd4_t      score_w;

  // Collision terms
  logic [11:0] bird_y12, ax12, ay12, bx12, by12;
  logic        x_ovl_a, in_gap_a, x_ovl_b, in_gap_b, hit_bound, hit_d;

  assign start_rise = start & ~start_prev_q;

  assign bird_y12 = {1'b0, birdy_q};
  assign ax12     = {1'b0, ax_q};
  assign ay12     = {1'b0, ay_q};
  assign bx12     = {1'b0, bx_q};
  assign by12     = {1'b0, by_q};

  // Sums only on both sides of every compare, so no subtraction can underflow
  assign x_ovl_a   = (ax12 >= C_X_LO) && (ax12 <= C_X_HI);
  assign in_gap_a  = (bird_y12 + C_GAP >= ay12) && (bird_y12 + C_BH_M1 <= ay12 + C_GAP);
  assign x_ovl_b   = (bx12 >= C_X_LO) && (bx12 <= C_X_HI);
  assign in_gap_b  = (bird_y12 + C_GAP >= by12) && (bird_y12 + C_BH_M1 <= by12 + C_GAP);
  assign hit_bound = (bird_y12 < C_PAD) || (bird_y12 + C_BH > C_Y_MAX);
  assign hit_d     = (x_ovl_a && !in_gap_a) || (x_ovl_b && !in_gap_b) || hit_bound;

  // Leaving IDLE discards any hit or pass computed while frozen
  assign flush = (state_q == ST_IDLE) && start_rise;

  // Start edge history; resets high so a button held through reset is ignored
  always_ff @(posedge gameClk) begin
    if (!reset) begin
      start_prev_q <= 1'b1;
    end else begin
      start_prev_q <= start;
    end
  end

  // Two-stage collision pipeline
  always_ff @(posedge gameClk) begin
    if (!reset) begin
      birdy_q <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      pass1_q <= 1'b0;
      hit_q   <= 1'b0;
      pass2_q <= 1'b0;
    end else begin
      birdy_q <= birdY;
      ax_q    <= Ax;
      ay_q    <= Ay;
      bx_q    <= Bx;
      by_q    <= By;
      if (flush) begin
        pass1_q <= 1'b0;
        hit_q   <= 1'b0;
        pass2_q <= 1'b0;
      end else begin
        pass1_q <= passColumn;
        hit_q   <= hit_d;
        pass2_q <= pass1_q;
      end
    end
  end

  // Game state transitions; a hit always beats a simultaneous pass
  always_comb begin
    state_d    = state_q;
    collided_d = 1'b0;
    score_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d   = ST_PLAY;
          score_clr = 1'b1;
        end
      end
      ST_PLAY: begin
        if (hit_q) begin
          state_d    = ST_DEAD;
          collided_d = 1'b1;
        end
      end
      ST_DEAD: begin
        if (start_rise) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign score_inc = (state_q == ST_PLAY) && !hit_q && pass2_q;

  // State and registered status outputs
  always_ff @(posedge gameClk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      finished_q <= 1'b1;
      collided_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      finished_q <= (state_d != ST_PLAY);
      collided_q <= collided_d;
    end
  end

  column_collision_scorer_bcd_counter4 u_score (
    .clk_i   (gameClk),
    .clr_ni  (reset & ~score_clr),
    .inc_i   (score_inc),
    .count_o (score_w)
  );

`ifdef HISCORE_EN
  logic [15:0] hi_q;

  // Capture a new best score at the moment of death
  always_ff @(posedge gameClk) begin
    if (!reset) begin
      hi_q <= '0;
    end else if (collided_d && bcd_gt(score_w, hi_q)) begin
      hi_q <= score_w;
    end
  end

  assign hiScore = hi_q;
`endif

  assign finished  = finished_q;
  assign collided  = collided_q;
  assign score     = score_w;
  assign gameState = state_q;

endmodule

`default_nettype wire

// File: tb/tb_column_collision_scorer.sv
// ============================================================================
// Module  : tb_column_collision_scorer
// Brief   : Scoreboard bench for column_collision_scorer. Expectations are
//           queued with a due cycle when stimulus is driven and compared on
//           the falling edge of that cycle. Define HISCORE_EN to cover the
//           high-score port as well.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_column_collision_scorer;

  logic        gameClk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] birdY, Ax, Ay, Bx, By;
  logic        passColumn;
  logic        finished, collided;
  logic [15:0] score;
  logic [1:0]  gameState;
  logic [15:0] hi_obs;
`ifdef HISCORE_EN
  logic [15:0] hiScore;
  assign hi_obs = hiScore;
`else
  assign hi_obs = 16'h0;
`endif

  column_collision_scorer dut (
    .gameClk    (gameClk),
    .reset      (reset),
    .start      (start),
    .birdY      (birdY),
    .Ax         (Ax),
    .Ay         (Ay),
    .Bx         (Bx),
    .By         (By),
    .passColumn (passColumn),
    .finished   (finished),
    .collided   (collided),
    .score      (score),
    .gameState  (gameState)
`ifdef HISCORE_EN
    ,
    .hiScore    (hiScore)
`endif
  );

  always #5 gameClk = ~gameClk;

  typedef struct {
    int          due;
    string       tag;
    logic [1:0]  st;
    logic        fin;
    logic        col;
    logic [15:0] sc;
    logic [15:0] hi;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [15:0] exp_hi = 16'h0;

  always @(posedge gameClk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard consumer: compares every expectation due this cycle
  always @(negedge gameClk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, ".state"},    {30'd0, gameState}, {30'd0, e.st});
      check({e.tag, ".finished"}, {31'd0, finished},  {31'd0, e.fin});
      check({e.tag, ".collided"}, {31'd0, collided},  {31'd0, e.col});
      check({e.tag, ".score"},    {16'd0, score},     {16'd0, e.sc});
`ifdef HISCORE_EN
      check({e.tag, ".hiScore"},  {16'd0, hi_obs},    {16'd0, e.hi});
`endif
    end
  end

  // Drive one cycle of stimulus just after a rising edge
  task automatic drive(input int by_, input int ax_, input int ay_, input int bx_,
                       input logic pass_, input logic start_, input logic rst_);
    @(posedge gameClk);
    #1;
    birdY      = 11'(by_);
    Ax         = 11'(ax_);
    Ay         = 11'(ay_);
    Bx         = 11'(bx_);
    By         = 11'd200;
    passColumn = pass_;
    start      = start_;
    reset      = rst_;
  endtask

  task automatic expect_at(input int lat, input string tag, input logic [1:0] st,
                           input logic fin, input logic col, input logic [15:0] sc);
    exp_t e;
    e.due = cyc + lat;
    e.tag = tag;
    e.st  = st;
    e.fin = fin;
    e.col = col;
    e.sc  = sc;
    e.hi  = exp_hi;
    sb.push_back(e);
  endtask

  // Safe idle stimulus: bird mid-screen, columns far to the right
  task automatic safe(input logic start_);
    drive(170, 600, 200, 600, 1'b0, start_, 1'b1);
  endtask

  // Wait (bounded) until all queued expectations have been compared
  task automatic settle();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(posedge gameClk);
      n++;
    end
    @(negedge gameClk);
    if (sb.size() > 0) begin
      check("scoreboard_drain", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic add_points(input int n, input logic [15:0] sc_after);
    for (int i = 0; i < n; i++) begin
      drive(170, 600, 200, 600, 1'b1, 1'b0, 1'b1);
      safe(1'b0);
    end
    expect_at(3, "points", 2'b01, 1'b0, 1'b0, sc_after);
    settle();
  endtask

  // DEAD -> IDLE -> PLAY with safe inputs
  task automatic restart(input logic [15:0] held);
    safe(1'b0);
    safe(1'b1);
    expect_at(1, "to_idle", 2'b00, 1'b1, 1'b0, held);
    safe(1'b0);
    safe(1'b1);
    expect_at(1, "to_play", 2'b01, 1'b0, 1'b0, 16'h0000);
    safe(1'b0);
    settle();
  endtask

  // Die by a given stimulus, checking the cycle before, the pulse and after
  task automatic die(input string tag, input int by_, input int ax_, input int bx_,
                     input logic pass_, input logic [15:0] sc);
    drive(by_, ax_, 200, bx_, pass_, 1'b0, 1'b1);
    expect_at(2, {tag, "_pre"}, 2'b01, 1'b0, 1'b0, sc);
`ifdef HISCORE_EN
    if (sc > exp_hi) exp_hi = sc;
`endif
    expect_at(3, tag, 2'b10, 1'b1, 1'b1, sc);
    expect_at(4, {tag, "_post"}, 2'b10, 1'b1, 1'b0, sc);
    settle();
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; passColumn = 1'b0;
    birdY = 11'd170; Ax = 11'd600; Ay = 11'd200; Bx = 11'd600; By = 11'd200;

    // Reset held with start high
    drive(170, 600, 200, 600, 1'b0, 1'b1, 1'b0);
    drive(170, 600, 200, 600, 1'b0, 1'b1, 1'b0);
    expect_at(0, "reset", 2'b00, 1'b1, 1'b0, 16'h0000);
    settle();
    // Release with start still held: must stay IDLE
    safe(1'b1);
    safe(1'b1);
    safe(1'b1);
    expect_at(1, "held_start", 2'b00, 1'b1, 1'b0, 16'h0000);
    settle();

    // Start a game
    safe(1'b0);
    safe(1'b1);
    expect_at(1, "start", 2'b01, 1'b0, 1'b0, 16'h0000);
    safe(1'b0);
    settle();

    // Safe pass through column A gap, score one point
    drive(170, 150, 200, 600, 1'b1, 1'b0, 1'b1);
    expect_at(2, "pass_pre", 2'b01, 1'b0, 1'b0, 16'h0000);
    expect_at(3, "pass", 2'b01, 1'b0, 1'b0, 16'h0001);
    drive(170, 150, 200, 600, 1'b0, 1'b0, 1'b1);
    expect_at(3, "pass_hold", 2'b01, 1'b0, 1'b0, 16'h0001);
    settle();

    // Gap top edge is still safe (140 + 60 == 200)
    drive(140, 150, 200, 600, 1'b0, 1'b0, 1'b1);
    expect_at(3, "gap_edge", 2'b01, 1'b0, 1'b0, 16'h0001);
    settle();

    // Column A hit above the gap
    die("hit_a", 130, 150, 600, 1'b0, 16'h0001);

    // Ceiling / floor boundaries
    restart(16'h0001);
    drive(10, 600, 200, 600, 1'b0, 1'b0, 1'b1);
    expect_at(3, "y10_safe", 2'b01, 1'b0, 1'b0, 16'h0000);
    drive(454, 600, 200, 600, 1'b0, 1'b0, 1'b1);
    expect_at(3, "y454_safe", 2'b01, 1'b0, 1'b0, 16'h0000);
    settle();
    die("ceiling", 9, 600, 600, 1'b0, 16'h0000);
    restart(16'h0000);
    die("floor", 455, 600, 600, 1'b0, 16'h0000);

    // Column B hit
    restart(16'h0000);
    die("hit_b", 130, 600, 150, 1'b0, 16'h0000);

    // Hit and pass together at 0041: hit wins
    restart(16'h0000);
    add_points(41, 16'h0041);
    die("hit_pass", 130, 150, 600, 1'b1, 16'h0041);

    // New game, lower score leaves the best score alone
    restart(16'h0041);
    add_points(3, 16'h0003);
    die("low_death", 130, 150, 600, 1'b0, 16'h0003);

    // Reset in the middle of a game
    restart(16'h0003);
    add_points(2, 16'h0002);
    drive(170, 600, 200, 600, 1'b0, 1'b0, 1'b0);
    exp_hi = 16'h0000;
    expect_at(1, "mid_reset", 2'b00, 1'b1, 1'b0, 16'h0000);
    safe(1'b0);
    settle();

    // Saturation at 9999
    safe(1'b1);
    expect_at(1, "sat_start", 2'b01, 1'b0, 1'b0, 16'h0000);
    safe(1'b0);
    settle();
    add_points(9999, 16'h9999);
    add_points(1, 16'h9999);

    settle();
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/column_collision_scorer.md
Name: column_collision_scorer

Overview:
- Consumer end of the column generator interface: takes column positions (Ax/Ay/Bx/By), the passColumn pulse and the bird's vertical position.
- Detects collisions with columns, floor and ceiling, and keeps a 4-digit BCD score.
- Drives the `finished` signal that the column generator and game logic consume.
- Sits between column generation/bird physics and the VGA/seven-segment display logic, all on gameClk.

Parameters:
- SCREEN_HEIGHT, 480, visible height in pixels.
- PADDING, 10, dead band at top and bottom; entering it is a collision.
- PIPE_W, 20, pipe_width; a column spans 2*PIPE_W offset units.
- GAP_H, 60, gap half-height about column gap centre.
- BIRD_X, 100, fixed screen x of bird's left edge.
- BIRD_W, 16, bird width.
- BIRD_H, 16, bird height.

Ports:
- gameClk  in  1  game tick clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  start/restart request, level; edge-detected internally.
- birdY  in  11  y of bird's top edge.
- Ax  in  11  column A right-side offset.
- Ay  in  11  column A gap centre.
- Bx  in  11  column B right-side offset.
- By  in  11  column B gap centre.
- passColumn  in  1  one-tick pulse when a column wraps.
- finished  out  1  high in IDLE and DEAD (freezes columns/bird).
- collided  out  1  one-cycle pulse on PLAY->DEAD.
- score  out  16  4-digit BCD score.
- gameState  out  2  00 IDLE, 01 PLAY, 10 DEAD.

Behaviour:
- Reset (reset==0 at gameClk edge), applied from any state including mid-game:
  - state=IDLE, finished=1, collided=0, score=0.
  - Pipeline registers and start edge detector cleared (prev start=1, so a held button does not fire).
- startRise = start & ~startPrev.
- Stage 1 registers birdY, Ax, Ay, Bx, By, passColumn.
- Stage 2 computes per column c, using only additive compares (no underflow, no signed math):
  - xOverlap(c) = (cx >= BIRD_X) && (cx <= BIRD_X + BIRD_W + 2*PIPE_W - 2).
  - inGap(c) = (birdY + GAP_H >= cy) && (birdY + BIRD_H - 1 <= cy + GAP_H).
  - hitCol(c) = xOverlap(c) && !inGap(c).
  - hitBound = (birdY < PADDING) || (birdY + BIRD_H > SCREEN_HEIGHT - PADDING).
  - hit = hitCol(A) | hitCol(B) | hitBound, registered.
- Latency: input change to collided/finished rising is 3 gameClk edges (2 pipeline stages + state update).
- FSM transitions:
  - IDLE: startRise -> PLAY; score cleared to 0; pipeline hit flags flushed so a stale hit cannot kill the first tick.
  - PLAY: hit -> DEAD, collided=1 for one cycle. Otherwise the delayed passColumn increments score.
  - DEAD: startRise -> IDLE; score held until IDLE->PLAY.
- Simultaneous hit and passColumn in the same stage-2 cycle: hit wins, no increment.
- BCD increment: carry ripples digit by digit. 9999 saturates (no wrap).
- finished = (state != PLAY), registered.
- Arithmetic: all compares at 12 bits (one guard bit) so sums of 11-bit values never overflow.

Optional Feature:
- HISCORE_EN defined:
  - Adds output hiScore[15:0] BCD, reset to 0.
  - On PLAY->DEAD, if score > hiScore (BCD compare digit-wise from MSD), hiScore <= score.
  - hiScore is cleared only by reset, not by IDLE.
- HISCORE_EN undefined: port and register absent; behaviour otherwise identical.

Decomposition:
- Shared constants (SCREEN_WIDTH, SCREEN_HEIGHT, PADDING, pipe_width, gap/bird geometry) and the gameState encodings live in constants.v.
- One natural sub-module: bcd_counter4 (sync active-low clear, inc, saturate at 9999, 16-bit BCD out). Instantiated once.
- Collision compares stay inline.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 -> finished=1, gameState=00, score=0000. Releasing reset with start held high must not enter PLAY.
- Safe pass: start pulse; Ax=150, Ay=200, birdY=170, Bx=600 -> no collision. passColumn pulse -> score=0001 three cycles later, finished stays 0.
- Column hit: PLAY, Ax=150, Ay=200, birdY=130 (above gap top 140) -> collided pulse and finished=1 on the third edge; gameState=10.
- Boundary: birdY=9 -> DEAD. birdY=10 with no column overlap -> stays PLAY. birdY=455 -> DEAD (455+16 > 470).
- Simultaneous: hit and passColumn in the same cycle at score=0041 -> DEAD with score=0041. Separately, preload 9999 and pulse passColumn -> 9999.
- Restart / HISCORE_EN: DEAD at 0041 -> hiScore=0041. Then start -> IDLE, start -> PLAY with score=0000; dying at 0003 leaves hiScore=0041. Reset mid-PLAY -> all outputs at reset values next edge.
